// File: rtl/idct_1d_control_unit.sv
// Sequencer for the 1-D IDCT datapath: multiply phase (4 operand selects), one empty slot, then butterfly-add.
// Optional macro IDCT_CTRL_BACK_TO_BACK_EN lets a new vector start directly from ST_ADDER_2.
module idct_1d_control_unit #(
  parameter int ROWS  = 8,
  parameter int ROW_W = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start_Calc,
  input  logic             Block_Sync,
  output logic [1:0]       Sele,
  output logic             Load_En,
  output logic             End_Calc,
  output logic             End_Block,
  output logic [ROW_W-1:0] Row_Idx,
  output logic             Busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b000,
    ST_MULT_1  = 3'b001,
    ST_MULT_2  = 3'b011,
    ST_MULT_3  = 3'b010,
    ST_MULT_4  = 3'b110,
    ST_EMPTY   = 3'b111,
    ST_ADDER_1 = 3'b101,
    ST_ADDER_2 = 3'b100
  } state_e;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  state_e           state_q, state_d;
  logic [1:0]       sele_q, sele_d;
  logic             load_en_q, load_en_d;
  logic             end_calc_q, end_calc_d;
  logic             end_block_q, end_block_d;
  logic             busy_q, busy_d;
  logic [ROW_W-1:0] row_q, row_d;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = ST_IDLE;
    sele_d      = 2'b00;
    load_en_d   = 1'b0;
    end_calc_d  = 1'b0;
    end_block_d = 1'b0;
    busy_d      = (state_q != ST_IDLE);
    row_d       = row_q;

    // Row advances on the edge where the End_Calc pulse ends.
    if (end_calc_q) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (Block_Sync) row_d = '0;
        state_d = Start_Calc ? ST_MULT_1 : ST_IDLE;
      end
      ST_MULT_1: begin
        load_en_d = 1'b1;
        state_d   = ST_MULT_2;
      end
      ST_MULT_2: begin
        sele_d  = 2'b01;
        state_d = ST_MULT_3;
      end
      ST_MULT_3: begin
        sele_d  = 2'b10;
        state_d = ST_MULT_4;
      end
      ST_MULT_4: begin
        sele_d  = 2'b11;
        state_d = ST_EMPTY;
      end
      ST_EMPTY:   state_d = ST_ADDER_1;
      ST_ADDER_1: state_d = ST_ADDER_2;
      ST_ADDER_2: begin
        end_calc_d  = 1'b1;
        end_block_d = (row_q == ROW_LAST);
`ifdef IDCT_CTRL_BACK_TO_BACK_EN
        state_d     = Start_Calc ? ST_MULT_1 : ST_IDLE;
`else
        state_d     = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      sele_q      <= 2'b00;
      load_en_q   <= 1'b0;
      end_calc_q  <= 1'b0;
      end_block_q <= 1'b0;
      busy_q      <= 1'b0;
      row_q       <= '0;
    end else begin
      state_q     <= state_d;
      sele_q      <= sele_d;
      load_en_q   <= load_en_d;
      end_calc_q  <= end_calc_d;
      end_block_q <= end_block_d;
      busy_q      <= busy_d;
      row_q       <= row_d;
    end
  end

  assign Sele      = sele_q;
  assign Load_En   = load_en_q;
  assign End_Calc  = end_calc_q;
  assign End_Block = end_block_q;
  assign Busy      = busy_q;
  assign Row_Idx   = row_q;

endmodule

// File: tb/tb_idct_1d_control_unit.sv
// Self-checking bench for idct_1d_control_unit: per-scenario tasks plus an End_Calc scoreboard.
// Honours IDCT_CTRL_BACK_TO_BACK_EN to select the expected start-to-start period.
module tb_idct_1d_control_unit;

  localparam int ROWS = 8;
`ifdef IDCT_CTRL_BACK_TO_BACK_EN
  localparam int P = 7;
`else
  localparam int P = 8;
`endif

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start_Calc = 1'b0;
  logic       Block_Sync = 1'b0;
  logic [1:0] Sele;
  logic       Load_En, End_Calc, End_Block, Busy;
  logic [2:0] Row_Idx;

  int ntests = 0;
  int nfail  = 0;
  int edge_n = 0;
  logic [2:0] exp_row = 3'd0;

  typedef struct {
    int         e;
    logic [2:0] row;
    logic       eb;
  } exp_t;
  exp_t sb[$];

  idct_1d_control_unit #(.ROWS(ROWS), .ROW_W(3)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start_Calc (Start_Calc),
    .Block_Sync (Block_Sync),
    .Sele       (Sele),
    .Load_En    (Load_En),
    .End_Calc   (End_Calc),
    .End_Block  (End_Block),
    .Row_Idx    (Row_Idx),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) edge_n <= edge_n + 1;

  // Scoreboard: every End_Calc pulse must match the oldest expected vector.
  always @(posedge Clock) begin : monitor
    exp_t x;
    #2;
    if (End_Calc) begin
      ntests++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL sb_unexpected_end edge=%0d row=%0d", edge_n, Row_Idx);
      end else begin
        x = sb.pop_front();
        if (edge_n !== x.e || Row_Idx !== x.row || End_Block !== x.eb) begin
          nfail++;
          $display("FAIL sb_end got edge=%0d row=%0d eb=%b exp edge=%0d row=%0d eb=%b",
                   edge_n, Row_Idx, End_Block, x.e, x.row, x.eb);
        end
      end
    end else begin
      ntests++;
      if (End_Block !== 1'b0) begin
        nfail++;
        $display("FAIL sb_block_without_end edge=%0d got=%b exp=0", edge_n, End_Block);
      end
      if (sb.size() > 0 && sb[0].e < edge_n) begin
        ntests++;
        nfail++;
        $display("FAIL sb_missed_end edge=%0d got=none exp_edge=%0d", edge_n, sb[0].e);
        x = sb.pop_front();
      end
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_vec(input int t0);
    exp_t x;
    x.e   = t0 + 7;
    x.row = exp_row;
    x.eb  = (exp_row == 3'(ROWS - 1));
    sb.push_back(x);
    exp_row = (exp_row == 3'(ROWS - 1)) ? 3'd0 : exp_row + 3'd1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Start_Calc = 1'b0;
    Block_Sync = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    exp_row = 3'd0;
    sb.delete();
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick();
    tick();
    ntests++;
    if ({Sele, Load_En, End_Calc, End_Block, Busy} !== 6'b0) begin
      nfail++;
      $display("FAIL reset_outputs got=%b exp=000000", {Sele, Load_En, End_Calc, End_Block, Busy});
    end
    ntests++;
    if (Row_Idx !== 3'd0) begin
      nfail++;
      $display("FAIL reset_row got=%0d exp=0", Row_Idx);
    end
    Reset = 1'b0;
    tick();
  endtask

  // One start pulse; checks Sele/Load_En/End_Calc/Busy for edges t0+1..t0+8 and the row step.
  task automatic test_single(input bit sync_busy);
    int t0;
    logic [2:0] r0, r1;
    logic [4:0] expv, got;
    r0 = exp_row;
    r1 = (r0 == 3'(ROWS - 1)) ? 3'd0 : r0 + 3'd1;
    Start_Calc = 1'b1;
    t0 = edge_n + 1;
    push_vec(t0);
    tick();
    Start_Calc = 1'b0;
    Block_Sync = sync_busy;
    for (int k = 1; k <= 8; k++) begin
      tick();
      expv[4:3] = (k <= 4) ? 2'(k - 1) : 2'b00;
      expv[2]   = (k == 1);
      expv[1]   = (k == 7);
      expv[0]   = (k <= 7);
      got = {Sele, Load_En, End_Calc, Busy};
      ntests++;
      if (got !== expv) begin
        nfail++;
        $display("FAIL single_t0+%0d {sele,ld,end,busy} got=%b exp=%b", k, got, expv);
      end
      ntests++;
      if (Row_Idx !== ((k < 8) ? r0 : r1)) begin
        nfail++;
        $display("FAIL single_row_t0+%0d got=%0d exp=%0d", k, Row_Idx, (k < 8) ? r0 : r1);
      end
      Block_Sync = sync_busy && (k < 6);
    end
    Block_Sync = 1'b0;
  endtask

  // Start held high for eight vectors: period P, End_Block on the 8th, row back to 0.
  task automatic test_continuous();
    int t0;
    logic eb;
    do_reset();
    Start_Calc = 1'b1;
    t0 = edge_n + 1;
    for (int v = 0; v < 8; v++) push_vec(t0 + v * P);
    tick();
    for (int k = 1; k <= 7 * P + 9; k++) begin
      tick();
      if (k == 7 * P) Start_Calc = 1'b0;
      if (k <= 7 * P + 8) begin
        eb = (k == 7 * P + 8) ? 1'b0 : ((P == 8) ? ((k % 8) != 0) : 1'b1);
        ntests++;
        if (Busy !== eb) begin
          nfail++;
          $display("FAIL cont_busy_t0+%0d got=%b exp=%b", k, Busy, eb);
        end
      end
      if (k == 7 * P + 8) begin
        ntests++;
        if (Row_Idx !== 3'd0) begin
          nfail++;
          $display("FAIL cont_row_wrap got=%0d exp=0", Row_Idx);
        end
      end
    end
    ntests++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL cont_pending got=%0d exp=0", sb.size());
    end
  endtask

  // Start pulse at t0+3 must be dropped.
  task automatic test_ignore_mid();
    int t0;
    Start_Calc = 1'b1;
    t0 = edge_n + 1;
    push_vec(t0);
    tick();
    Start_Calc = 1'b0;
    tick();
    tick();
    Start_Calc = 1'b1;
    tick();
    Start_Calc = 1'b0;
    for (int k = 4; k <= 8; k++) tick();
    ntests++;
    if (Busy !== 1'b0) begin
      nfail++;
      $display("FAIL ignore_busy_t0+8 got=%b exp=0", Busy);
    end
    tick();
    ntests++;
    if (Busy !== 1'b0) begin
      nfail++;
      $display("FAIL ignore_busy_t0+9 got=%b exp=0", Busy);
    end
    ntests++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL ignore_pending got=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_block_sync();
    int t0;
    do_reset();
    test_single(1'b0);
    test_single(1'b0);
    test_single(1'b1);
    ntests++;
    if (Row_Idx !== 3'd3) begin
      nfail++;
      $display("FAIL bsync_row_before got=%0d exp=3", Row_Idx);
    end
    Block_Sync = 1'b1;
    Start_Calc = 1'b1;
    exp_row = 3'd0;
    t0 = edge_n + 1;
    push_vec(t0);
    tick();
    Block_Sync = 1'b0;
    Start_Calc = 1'b0;
    ntests++;
    if (Row_Idx !== 3'd0) begin
      nfail++;
      $display("FAIL bsync_row_start got=%0d exp=0", Row_Idx);
    end
    for (int k = 1; k <= 8; k++) tick();
    ntests++;
    if (Row_Idx !== 3'd1) begin
      nfail++;
      $display("FAIL bsync_row_after got=%0d exp=1", Row_Idx);
    end
  endtask

  task automatic test_reset_mid();
    Start_Calc = 1'b1;
    tick();
    Start_Calc = 1'b0;
    tick();
    tick();
    #1;
    Reset = 1'b1;
    #1;
    ntests++;
    if ({Sele, Load_En, End_Calc, End_Block, Busy} !== 6'b0) begin
      nfail++;
      $display("FAIL rstmid_outputs got=%b exp=000000", {Sele, Load_En, End_Calc, End_Block, Busy});
    end
    ntests++;
    if (Row_Idx !== 3'd0) begin
      nfail++;
      $display("FAIL rstmid_row got=%0d exp=0", Row_Idx);
    end
    tick();
    Reset = 1'b0;
    exp_row = 3'd0;
    for (int k = 0; k < 10; k++) tick();
    test_single(1'b0);
  endtask

  initial begin
    test_reset();
    test_single(1'b0);
    test_continuous();
    test_ignore_mid();
    test_block_sync();
    test_reset_mid();
    tick();
    tick();
    ntests++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL final_pending got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
